// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter: entry layout, source IDs
// and a saturating counter helper used by the optional statistics (WB_STATS_EN).
package regfile_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the producers/hazard unit (master) and the write-back arbiter (slave).
interface regfile_wb_arbiter_if;
  import regfile_wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              rg_wrt_en;
  logic [REG_AW-1:0] rg_wrt_addr;
  logic [XLEN-1:0]   rg_wrt_data;
  logic [REG_AW-1:0] chk_addr1;
  logic [REG_AW-1:0] chk_addr2;
  logic              chk_pend1;
  logic              chk_pend2;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_addr1, chk_addr2,
    output alu_ready, mem_ready, rg_wrt_en, rg_wrt_addr, rg_wrt_data, chk_pend1, chk_pend2
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_addr1, chk_addr2,
    input  alu_ready, mem_ready, rg_wrt_en, rg_wrt_addr, rg_wrt_data, chk_pend1, chk_pend2
  );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small write-back FIFO; also exposes every slot's rd and occupancy for hazard compares.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  wb_entry_t         wr_entry_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output wb_entry_t         head_o,
  output logic [REG_AW-1:0] ent_rd_o  [DEPTH],
  output logic              ent_vld_o [DEPTH]
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  // Storage carries no reset: emptiness is tracked purely by the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_entry_i;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    logic [AW-1:0] off;
    assign off            = AW'(gi) - rd_ptr_q;
    assign ent_vld_o[gi]  = ({1'b0, off} < count_q);
    assign ent_rd_o[gi]   = mem_q[gi].rd;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source write-back arbiter feeding the single register-file write port.
// Optional WB_STATS_EN adds x0-drop and forced-ALU-win counters.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
`ifdef WB_STATS_EN
  ,
  output logic [15:0]          stat_x0_drops,
  output logic [15:0]          stat_starve
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t         alu_in, mem_in, alu_head, mem_head, pop_entry, out_q;
  logic              alu_full, alu_empty, mem_full, mem_empty;
  logic              alu_push, mem_push, pop_alu, pop_mem, wrt_en_q;
  logic [REG_AW-1:0] alu_rdv [DEPTH];
  logic [REG_AW-1:0] mem_rdv [DEPTH];
  logic              alu_vld [DEPTH];
  logic              mem_vld [DEPTH];
  logic [SW-1:0]     starve_q, starve_d;
  wb_src_e           win_src;
  logic              pend1, pend2;

  assign alu_in        = '{rd: bus.alu_rd, data: bus.alu_data};
  assign mem_in        = '{rd: bus.mem_rd, data: bus.mem_data};
  assign bus.alu_ready = !alu_full && !reset;
  assign bus.mem_ready = !mem_full && !reset;
  // x0 results are consumed by the handshake but never buffered.
  assign alu_push      = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
  assign mem_push      = bus.mem_valid && bus.mem_ready && (bus.mem_rd != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .reset(reset), .push_i(alu_push), .wr_entry_i(alu_in), .pop_i(pop_alu),
    .full_o(alu_full), .empty_o(alu_empty), .head_o(alu_head),
    .ent_rd_o(alu_rdv), .ent_vld_o(alu_vld)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk(clk), .reset(reset), .push_i(mem_push), .wr_entry_i(mem_in), .pop_i(pop_mem),
    .full_o(mem_full), .empty_o(mem_empty), .head_o(mem_head),
    .ent_rd_o(mem_rdv), .ent_vld_o(mem_vld)
  );

  always_comb begin
    pop_alu  = 1'b0;
    pop_mem  = 1'b0;
    win_src  = SRC_MEM;
    starve_d = '0;
    if (!alu_empty && !mem_empty) begin
      if (starve_q == SW'(STARVE_LIMIT)) begin
        pop_alu = 1'b1;
        win_src = SRC_ALU;
      end else begin
        pop_mem  = 1'b1;
        starve_d = starve_q + SW'(1);
      end
    end else if (!alu_empty) begin
      pop_alu = 1'b1;
      win_src = SRC_ALU;
    end else if (!mem_empty) begin
      pop_mem = 1'b1;
    end
  end

  assign pop_entry = (win_src == SRC_ALU) ? alu_head : mem_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      wrt_en_q <= 1'b0;
      out_q    <= '0;
    end else begin
      starve_q <= starve_d;
      wrt_en_q <= pop_alu || pop_mem;
      if (pop_alu || pop_mem) out_q <= pop_entry;
    end
  end

  assign bus.rg_wrt_en   = wrt_en_q;
  assign bus.rg_wrt_addr = out_q.rd;
  assign bus.rg_wrt_data = out_q.data;

  always_comb begin
    pend1 = wrt_en_q && (out_q.rd == bus.chk_addr1);
    pend2 = wrt_en_q && (out_q.rd == bus.chk_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if ((alu_vld[i] && alu_rdv[i] == bus.chk_addr1) || (mem_vld[i] && mem_rdv[i] == bus.chk_addr1))
        pend1 = 1'b1;
      if ((alu_vld[i] && alu_rdv[i] == bus.chk_addr2) || (mem_vld[i] && mem_rdv[i] == bus.chk_addr2))
        pend2 = 1'b1;
    end
  end

  assign bus.chk_pend1 = pend1 && (bus.chk_addr1 != '0);
  assign bus.chk_pend2 = pend2 && (bus.chk_addr2 != '0);

`ifdef WB_STATS_EN
  logic        alu_drop, mem_drop, forced_win;
  logic [15:0] x0_cnt_q, starve_cnt_q;

  assign alu_drop   = bus.alu_valid && bus.alu_ready && (bus.alu_rd == '0);
  assign mem_drop   = bus.mem_valid && bus.mem_ready && (bus.mem_rd == '0);
  // ALU only wins against a non-empty MEM FIFO when the starvation limit forces it.
  assign forced_win = pop_alu && !mem_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_cnt_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      x0_cnt_q     <= sat_add16(x0_cnt_q, {1'b0, alu_drop} + {1'b0, mem_drop});
      starve_cnt_q <= sat_add16(starve_cnt_q, {1'b0, forced_win});
    end
  end

  assign stat_x0_drops = x0_cnt_q;
  assign stat_starve   = starve_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=2, STARVE_LIMIT=4); stats checks under WB_STATS_EN.
module tb_regfile_wb_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

`ifdef WB_STATS_EN
  logic [15:0] stat_x0_drops, stat_starve;
`endif

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef WB_STATS_EN
    ,
    .stat_x0_drops (stat_x0_drops),
    .stat_starve   (stat_starve)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected write stream for the contention test, indexed by edge number.
  logic        t2_en   [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [4:0]  t2_rd   [11] = '{0, 4, 4, 4, 4, 3, 4, 4, 3, 3, 0};
  logic [31:0] t2_data [11] = '{32'h0, 32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003,
                                32'hA0000000, 32'hB0000004, 32'hB0000005, 32'hA0000001,
                                32'hA0000002, 32'h0};
  logic [4:0]  t5_rd   [5]  = '{0, 7, 8, 9, 0};
  logic        t5_pend [5]  = '{0, 1, 1, 0, 0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.chk_addr1 = '0;   bus.chk_addr2 = '0;
  endtask

  // Drives ALU rd=3 / MEM rd=4 for edges 0..last_valid, advancing data per accepted transfer.
  task automatic run_pair(input int last_valid, input int n_edges, input logic do_check,
                          output int na, output int nm);
    logic a_acc, m_acc;
    na = 0; nm = 0;
    for (int k = 0; k < n_edges; k++) begin
      bus.alu_valid = (k <= last_valid); bus.alu_rd = 5'd3; bus.alu_data = 32'hA0000000 + na;
      bus.mem_valid = (k <= last_valid); bus.mem_rd = 5'd4; bus.mem_data = 32'hB0000000 + nm;
      #1;
      a_acc = bus.alu_valid && bus.alu_ready;
      m_acc = bus.mem_valid && bus.mem_ready;
      tick();
      if (a_acc) na++;
      if (m_acc) nm++;
      if (do_check && k < 11) begin
        check_eq($sformatf("pair_en[%0d]", k), 32'(bus.rg_wrt_en), 32'(t2_en[k]));
        if (t2_en[k]) begin
          check_eq($sformatf("pair_addr[%0d]", k), 32'(bus.rg_wrt_addr), 32'(t2_rd[k]));
          check_eq($sformatf("pair_data[%0d]", k), bus.rg_wrt_data, t2_data[k]);
        end
        if (k == 1) check_eq("pair_alu_ready_full", 32'(bus.alu_ready), 32'd0);
        if (k == 5) begin
          check_eq("pair_alu_ready_after_forced", 32'(bus.alu_ready), 32'd1);
          check_eq("pair_mem_ready_full", 32'(bus.mem_ready), 32'd0);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int na, nm;
    idle_inputs();
    #1 reset = 1'b1;
    #1;
    check_eq("rst_en",        32'(bus.rg_wrt_en),   32'd0);
    check_eq("rst_addr",      32'(bus.rg_wrt_addr), 32'd0);
    check_eq("rst_data",      bus.rg_wrt_data,      32'd0);
    check_eq("rst_alu_ready", 32'(bus.alu_ready),   32'd0);
    check_eq("rst_mem_ready", 32'(bus.mem_ready),   32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("post_rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    check_eq("post_rst_mem_ready", 32'(bus.mem_ready), 32'd1);

    // Single ALU write rd=5
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF; bus.chk_addr1 = 5'd5;
    #1;
    check_eq("t1_pend_before", 32'(bus.chk_pend1), 32'd0);
    tick();
    bus.alu_valid = 1'b0;
    check_eq("t1_e0_en",   32'(bus.rg_wrt_en), 32'd0);
    check_eq("t1_e0_pend", 32'(bus.chk_pend1), 32'd1);
    tick();
    check_eq("t1_e1_en",   32'(bus.rg_wrt_en),   32'd1);
    check_eq("t1_e1_addr", 32'(bus.rg_wrt_addr), 32'd5);
    check_eq("t1_e1_data", bus.rg_wrt_data,      32'hDEADBEEF);
    check_eq("t1_e1_pend", 32'(bus.chk_pend1),   32'd1);
    tick();
    check_eq("t1_e2_en",   32'(bus.rg_wrt_en),   32'd0);
    check_eq("t1_e2_addr", 32'(bus.rg_wrt_addr), 32'd5);
    check_eq("t1_e2_pend", 32'(bus.chk_pend1),   32'd0);
    idle_inputs();

    // Contention with starvation release
    run_pair(6, 11, 1'b1, na, nm);
    check_eq("pair_alu_accepted", 32'(na), 32'd3);
    check_eq("pair_mem_accepted", 32'(nm), 32'd6);

    // MEM x0 write
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h1234; bus.chk_addr2 = 5'd0;
    #1;
    check_eq("x0_mem_ready", 32'(bus.mem_ready), 32'd1);
    check_eq("x0_pend2",     32'(bus.chk_pend2), 32'd0);
    tick();
    bus.mem_valid = 1'b0;
    check_eq("x0_mem_ready_after", 32'(bus.mem_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("x0_en[%0d]", k), 32'(bus.rg_wrt_en), 32'd0);
      tick();
    end

    // Reset with buffered entries
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h10;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd11; bus.mem_data = 32'h11;
    tick(); tick();
    idle_inputs();
    bus.chk_addr1 = 5'd10; bus.chk_addr2 = 5'd11;
    #1;
    check_eq("fill_pend1", 32'(bus.chk_pend1), 32'd1);
    check_eq("fill_pend2", 32'(bus.chk_pend2), 32'd1);
    check_eq("fill_en",    32'(bus.rg_wrt_en), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_en",    32'(bus.rg_wrt_en), 32'd0);
    check_eq("mid_rst_pend1", 32'(bus.chk_pend1), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("after_rst_en[%0d]", k),    32'(bus.rg_wrt_en), 32'd0);
      check_eq($sformatf("after_rst_pend1[%0d]", k), 32'(bus.chk_pend1), 32'd0);
      check_eq($sformatf("after_rst_pend2[%0d]", k), 32'(bus.chk_pend2), 32'd0);
    end

    // MEM burst 7,8,9
    bus.chk_addr2 = 5'd8;
    for (int k = 0; k < 5; k++) begin
      bus.mem_valid = (k < 3); bus.mem_rd = 5'(7 + k); bus.mem_data = 32'h70 + 32'(16 * k);
      tick();
      check_eq($sformatf("burst_en[%0d]", k), 32'(bus.rg_wrt_en), (t5_rd[k] != 0) ? 32'd1 : 32'd0);
      if (t5_rd[k] != 0) begin
        check_eq($sformatf("burst_addr[%0d]", k), 32'(bus.rg_wrt_addr), 32'(t5_rd[k]));
        check_eq($sformatf("burst_data[%0d]", k), bus.rg_wrt_data, 32'h70 + 32'(16 * (k - 1)));
      end
      check_eq($sformatf("burst_pend2[%0d]", k), 32'(bus.chk_pend2), 32'(t5_pend[k]));
    end
    idle_inputs();

`ifdef WB_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("stat_x0_rst",     32'(stat_x0_drops), 32'd0);
    check_eq("stat_starve_rst", 32'(stat_starve),   32'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.mem_valid = 1'b1; bus.mem_rd = 5'd0;
    tick();
    bus.mem_valid = 1'b0;
    check_eq("stat_x0_dual", 32'(stat_x0_drops), 32'd2);
    tick();
    idle_inputs();
    check_eq("stat_x0_three", 32'(stat_x0_drops), 32'd3);
    run_pair(10, 17, 1'b0, na, nm);
    check_eq("stat_starve_two", 32'(stat_starve),   32'd2);
    check_eq("stat_x0_hold",    32'(stat_x0_drops), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
